// File: rtl/uart_pkg.sv
//============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types and constants (receiver states, frame sizing,
//            baud divisor used by the baud-rate generator).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned c_DATA_BITS   = 8;
  localparam int unsigned c_SYNC_STAGES = 2;
  localparam int unsigned c_CLK_HZ      = 50_000_000;
  localparam int unsigned c_BAUD        = 115_200;
  localparam int unsigned c_BAUD_DIV    = c_CLK_HZ / c_BAUD;
  localparam int unsigned c_BAUD_HALF   = c_BAUD_DIV / 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_sync.sv
//============================================================================
// Module   : uart_rx_sync
// Purpose  : Multi-stage synchronizer for the raw RX pin plus falling-edge
//            detector that flags a candidate start bit.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = c_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic start_edge_o
);

  // Flops reset to 1 so a reset release on an idle line never looks like a start edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_sync_o    = sync_q[SYNC_STAGES-1];
  assign start_edge_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule : uart_rx_sync

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
//============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive controller; samples on the baud generator's mid-bit
//            strobe and emits byte / framing / parity strobes.
//            Optional even parity enabled by macro UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = c_DATA_BITS,
  parameter int unsigned SYNC_STAGES = c_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned c_CNT_W = $clog2(DATA_BITS + 1);

  logic                 rx_sync;
  logic                 start_edge;

  rx_state_e            state_q;
  logic                 bps_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic [c_CNT_W-1:0]   cnt_q;
  logic                 valid_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q;
  logic                 perr_q;
`endif

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rs232_rx),
    .rx_sync_o    (rx_sync),
    .start_edge_o (start_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bps_q     <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q <= ST_START;
            bps_q   <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_bps) begin
            // A line already back high at mid-start-bit is a glitch, not a frame.
            if (!rx_sync) begin
              state_q <= ST_DATA;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              bps_q   <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (clk_bps) begin
            shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == c_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (clk_bps) begin
            par_bit_q <= rx_sync;
            state_q   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (clk_bps) begin
            state_q <= ST_IDLE;
            bps_q   <= 1'b0;
            if (!rx_sync) begin
              ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_bit_q}) begin
              perr_q <= 1'b1;
`endif
            end else begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          bps_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bps_start = bps_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule : uart_rx_ctrl

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
//============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl with a behavioural baud
//            generator and frame-level reference model (UART_RX_PARITY_EN aware).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int unsigned DB   = c_DATA_BITS;
  localparam int unsigned DIV  = c_BAUD_DIV;
  localparam int unsigned HALF = c_BAUD_HALF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rs232_rx = 1'b1;
  logic          clk_bps;
  logic          bps_start;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;

  uart_rx_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs232_rx   (rs232_rx),
    .clk_bps    (clk_bps),
    .bps_start  (bps_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #10 clk = ~clk;

  // Baud generator: first strobe half a bit after enable, then one per bit.
  int bcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= 0;
      clk_bps <= 1'b0;
    end else if (!bps_start) begin
      bcnt    <= 0;
      clk_bps <= 1'b0;
    end else begin
      bcnt    <= (bcnt == int'(DIV) - 1) ? 0 : bcnt + 1;
      clk_bps <= (bcnt == int'(HALF) - 1);
    end
  end

  typedef struct {
    int            kind;   // 0 valid, 1 frame error, 2 parity error
    logic [DB-1:0] data;
    logic          bps;
  } ev_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   excl_viol = 0;
  int   consec_viol = 0;
  int   bps_rises = 0;
  logic prev_any = 1'b0;
  logic prev_bps = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) excl_viol <= excl_viol + 1;
      if ((rx_valid | frame_err | parity_err) && prev_any) consec_viol <= consec_viol + 1;
      if (rx_valid)   obs_q.push_back('{0, rx_data, bps_start});
      if (frame_err)  obs_q.push_back('{1, rx_data, bps_start});
      if (parity_err) obs_q.push_back('{2, rx_data, bps_start});
      if (bps_start && !prev_bps) bps_rises <= bps_rises + 1;
    end
    prev_any <= rst_n & (rx_valid | frame_err | parity_err);
    prev_bps <= rst_n & bps_start;
  end

  int            checks = 0;
  int            errors = 0;
  logic [DB-1:0] last_good = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit(input logic v, input int unsigned nbits);
    rs232_rx = v;
    repeat (nbits * DIV) @(negedge clk);
  endtask

  // Reference outcome straight from the frame rules, then serialise the frame.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_ok,
                            input int unsigned low_hold, input int unsigned gap_bits);
    ev_t e;
    e.bps = 1'b0;
    if (!stop) begin
      e.kind = 1;  e.data = last_good;
`ifdef UART_RX_PARITY_EN
    end else if (!par_ok) begin
      e.kind = 2;  e.data = last_good;
`endif
    end else begin
      last_good = d;
      e.kind = 0;  e.data = d;
    end
    exp_q.push_back(e);
    hold_bit(1'b0, 1);
    for (int i = 0; i < int'(DB); i++) hold_bit(d[i], 1);
`ifdef UART_RX_PARITY_EN
    hold_bit((^d) ^ ~par_ok, 1);
`endif
    hold_bit(stop, 1);
    if (!stop && low_hold > 0) hold_bit(1'b0, low_hold);
    if (gap_bits > 0) hold_bit(1'b1, gap_bits);
    else rs232_rx = 1'b1;
  endtask

  task automatic verify(input string tag);
    int n;
    int w;
    w = 0;
    while (bps_start && w < int'(4 * DIV)) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_bps_timeout"}, 32'(bps_start), 32'd0);
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      ev_t o;
      ev_t x;
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      check({tag, "_kind"}, 32'(o.kind), 32'(x.kind));
      check({tag, "_data"}, 32'(o.data), 32'(x.data));
      check({tag, "_bps_at_strobe"}, 32'(o.bps), 32'(x.bps));
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_rx_data_hold"}, 32'(rx_data), 32'(last_good));
  endtask

  initial begin
    int r0;
    rs232_rx = 1'b1;
    rst_n    = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_bps",   32'(bps_start),  32'd0);
    check("reset_data",  32'(rx_data),    32'd0);
    check("reset_valid", 32'(rx_valid),   32'd0);
    check("reset_ferr",  32'(frame_err),  32'd0);
    check("reset_perr",  32'(parity_err), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h55, 1'b1, 1'b1, 0, 1);
    verify("f55");

    send_frame(8'hA3, 1'b1, 1'b1, 0, 0);
    send_frame(8'h0F, 1'b1, 1'b1, 0, 1);
    verify("b2b");

    // Short low glitch on an idle line must abort at the first mid-bit sample.
    r0 = bps_rises;
    hold_bit(1'b0, 0);
    repeat (100) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_bps_up", 32'(bps_start), 32'd1);
    repeat (DIV) @(negedge clk);
    check("glitch_bps_down", 32'(bps_start), 32'd0);
    check("glitch_rises", 32'(bps_rises - r0), 32'd1);
    check("glitch_no_strobe", 32'(obs_q.size()), 32'd0);

    // Framing error followed by a held break: exactly one start accepted.
    r0 = bps_rises;
    send_frame(8'h3C, 1'b0, 1'b1, 20, 1);
    check("break_no_retrigger", 32'(bps_rises - r0), 32'd1);
    verify("ferr3C");
    send_frame(8'h81, 1'b1, 1'b1, 0, 1);
    verify("f81");

    // Reset in the middle of a frame discards the partial byte.
    hold_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) hold_bit(1'b0, 1);
    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    #1;
    check("midrst_bps",   32'(bps_start),  32'd0);
    check("midrst_data",  32'(rx_data),    32'd0);
    check("midrst_valid", 32'(rx_valid),   32'd0);
    check("midrst_ferr",  32'(frame_err),  32'd0);
    check("midrst_perr",  32'(parity_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    last_good = '0;
    obs_q.delete();
    repeat (2 * DIV) @(negedge clk);
    check("midrst_quiet_bps", 32'(bps_start), 32'd0);
    check("midrst_quiet_ev",  32'(obs_q.size()), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 0, 1);
    verify("post_rst81");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0, 1);
    verify("par_bad07");
    send_frame(8'h07, 1'b1, 1'b1, 0, 1);
    verify("par_ok07");
`endif

    for (int k = 0; k < 3; k++) begin
      logic [DB-1:0] d;
      logic          stp;
      logic          pok;
      d   = DB'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      pok = ($urandom_range(0, 2) != 0);
      send_frame(d, stp, pok, 0, 1);
      verify("rand");
    end

    check("strobe_exclusive",   32'(excl_viol),   32'd0);
    check("strobe_consecutive", 32'(consec_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_ctrl

`default_nettype wire
